// File: rtl/biriq_branch_pkg.sv
// Shared types and constants for the branch resolution stage and its users.
package biriq_branch_pkg;

    // Micro-op kind; the reserved encoding resolves like a conditional branch.
    typedef enum logic [1:0] {
        KindBr   = 2'b00,
        KindJal  = 2'b01,
        KindJalr = 2'b10,
        KindRsvd = 2'b11
    } kind_e;

    // Branch condition codes (funct3).
    localparam logic [2:0] Funct3Beq  = 3'b000;
    localparam logic [2:0] Funct3Bne  = 3'b001;
    localparam logic [2:0] Funct3Blt  = 3'b100;
    localparam logic [2:0] Funct3Bge  = 3'b101;
    localparam logic [2:0] Funct3Bltu = 3'b110;
    localparam logic [2:0] Funct3Bgeu = 3'b111;

    // Resolution FSM states.
    typedef enum logic [0:0] {
        StIdle     = 1'b0,
        StRedirect = 1'b1
    } state_e;

    // Jumps write a link value and are unconditionally taken.
    function automatic logic is_link_kind(kind_e kind);
        return (kind == KindJal) || (kind == KindJalr);
    endfunction

endpackage

// File: rtl/biriq_branch_resolve_if.sv
// Issue, writeback and redirect bundle of the branch resolution stage.
interface biriq_branch_resolve_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned RobIdW = 6
);
    // Issue side
    logic              in_valid;
    logic              in_ready;
    logic [RobIdW-1:0] in_rob_id;
    logic [2:0]        in_funct3;
    logic [1:0]        in_kind;
    logic [XLEN-1:0]   in_pc;
    logic [XLEN-1:0]   in_imm;
    logic [XLEN-1:0]   in_rs1;
    logic              in_mts;
    logic              in_mtu;
    logic              in_eq;
    logic              in_pred_taken;
    logic [XLEN-1:0]   in_pred_target;
    // Writeback side
    logic              wb_valid;
    logic              wb_ready;
    logic [RobIdW-1:0] wb_rob_id;
    logic [XLEN-1:0]   wb_data;
    logic              wb_exc;
    // Frontend redirect
    logic              redirect;
    logic [XLEN-1:0]   redirect_pc;
    logic              redirect_ack;

    // Resolution stage side
    modport slave (
        input  in_valid, in_rob_id, in_funct3, in_kind, in_pc, in_imm, in_rs1,
        input  in_mts, in_mtu, in_eq, in_pred_taken, in_pred_target,
        output in_ready,
        output wb_valid, wb_rob_id, wb_data, wb_exc,
        input  wb_ready,
        output redirect, redirect_pc,
        input  redirect_ack
    );

    // Issue / ROB / frontend side
    modport master (
        output in_valid, in_rob_id, in_funct3, in_kind, in_pc, in_imm, in_rs1,
        output in_mts, in_mtu, in_eq, in_pred_taken, in_pred_target,
        input  in_ready,
        input  wb_valid, wb_rob_id, wb_data, wb_exc,
        output wb_ready,
        input  redirect, redirect_pc,
        output redirect_ack
    );

endinterface

// File: rtl/biriq_branch_cond.sv
// Branch condition evaluation from funct3 and the compare unit flags.
module biriq_branch_cond
    import biriq_branch_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       mts_i,    // rs1 > rs2 signed
    input  logic       mtu_i,    // rs1 > rs2 unsigned
    input  logic       eq_i,     // rs1 == rs2
    output logic       taken_o
);

    // Decode the condition; 010/011 are not branch conditions and never take.
    always_comb begin
        taken_o = 1'b0;
        case (funct3_i)
            Funct3Beq:  taken_o = eq_i;
            Funct3Bne:  taken_o = !eq_i;
            Funct3Blt:  taken_o = !(mts_i || eq_i);
            Funct3Bge:  taken_o = mts_i || eq_i;
            Funct3Bltu: taken_o = !(mtu_i || eq_i);
            Funct3Bgeu: taken_o = mtu_i || eq_i;
            default:    taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/biriq_branch_resolve.sv
// Branch/jump resolution stage: computes direction and target, checks the
// frontend prediction, writes back the link value and holds a redirect to the
// frontend on mispredict until acknowledged.
// Optional build macro BIRIQ_BRANCH_STATS_EN adds saturating resolve and
// mispredict counters.
module biriq_branch_resolve
    import biriq_branch_pkg::*;
#(
    parameter int unsigned C_XLEN            = 32,
    parameter int unsigned C_ROB_ID_W        = 6,
    parameter bit          C_HAS_C_EXTENSION = 1'b0
) (
    input  logic                  cpu_clock_i,
    input  logic                  cpu_resetn_i,
    input  logic                  flush_i,
`ifdef BIRIQ_BRANCH_STATS_EN
    output logic [31:0]           resolved_count_o,
    output logic [31:0]           mispredict_count_o,
`endif
    biriq_branch_resolve_if.slave bus
);

    state_e                  state_q, state_d;
    logic                    wb_valid_q, wb_valid_d;
    logic [C_ROB_ID_W-1:0]   wb_rob_id_q;
    logic [C_XLEN-1:0]       wb_data_q;
    logic                    wb_exc_q;
    logic [C_XLEN-1:0]       redirect_pc_q;

    kind_e                   kind;
    logic                    is_link;
    logic                    is_jalr;
    logic                    cond_taken;
    logic                    taken;
    logic [C_XLEN-1:0]       pc_plus4;
    logic [C_XLEN-1:0]       jalr_sum;
    logic [C_XLEN-1:0]       target;
    logic [C_XLEN-1:0]       next_pc;
    logic                    align_fault;
    logic                    mispredict;
    logic                    accept;
    logic                    raise_redirect;

    assign kind    = kind_e'(bus.in_kind);
    assign is_link = is_link_kind(kind);
    assign is_jalr = (kind == KindJalr);

    biriq_branch_cond u_cond (
        .funct3_i (bus.in_funct3),
        .mts_i    (bus.in_mts),
        .mtu_i    (bus.in_mtu),
        .eq_i     (bus.in_eq),
        .taken_o  (cond_taken)
    );

    // Direction, target and prediction check; all sums wrap modulo 2^XLEN.
    always_comb begin
        taken    = is_link || cond_taken;
        pc_plus4 = bus.in_pc + C_XLEN'(4);
        jalr_sum = bus.in_rs1 + bus.in_imm;
        if (is_jalr) begin
            target = jalr_sum & ~C_XLEN'(1);
        end else begin
            target = bus.in_pc + bus.in_imm;
        end
        next_pc     = taken ? target : pc_plus4;
        // Only a taken path can fault; halfword targets are legal with RVC.
        align_fault = !C_HAS_C_EXTENSION && taken && target[1];
        mispredict  = (bus.in_pred_taken != taken) ||
                      (taken && (bus.in_pred_target != target));
    end

    assign bus.in_ready   = (state_q == StIdle) && (!wb_valid_q || bus.wb_ready);
    assign accept         = bus.in_valid && bus.in_ready && !flush_i;
    // A faulting op traps through the ROB instead of steering the frontend.
    assign raise_redirect = accept && mispredict && !align_fault;

    // FSM next state; flush overrides everything, including an ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (raise_redirect) state_d = StRedirect;
            StRedirect: if (bus.redirect_ack) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
        if (flush_i) begin
            state_d = StIdle;
        end
    end

    // Writeback valid: new accept overwrites without a bubble, ready drains.
    always_comb begin
        wb_valid_d = wb_valid_q;
        if (flush_i) begin
            wb_valid_d = 1'b0;
        end else if (accept) begin
            wb_valid_d = 1'b1;
        end else if (bus.wb_ready) begin
            wb_valid_d = 1'b0;
        end
    end

    // State and valid registers.
    always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
        if (!cpu_resetn_i) begin
            state_q    <= StIdle;
            wb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
        end
    end

    // Writeback payload loads only on accept so it holds while stalled.
    always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
        if (!cpu_resetn_i) begin
            wb_rob_id_q <= '0;
            wb_data_q   <= '0;
            wb_exc_q    <= 1'b0;
        end else if (accept) begin
            wb_rob_id_q <= bus.in_rob_id;
            wb_data_q   <= is_link ? pc_plus4 : '0;
            wb_exc_q    <= align_fault;
        end
    end

    // Redirect PC captured alongside the writeback; stable while redirecting.
    always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
        if (!cpu_resetn_i) begin
            redirect_pc_q <= '0;
        end else if (raise_redirect) begin
            redirect_pc_q <= next_pc;
        end
    end

    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_rob_id   = wb_rob_id_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.wb_exc      = wb_exc_q;
    assign bus.redirect    = (state_q == StRedirect);
    assign bus.redirect_pc = redirect_pc_q;

`ifdef BIRIQ_BRANCH_STATS_EN
    logic [31:0] resolved_q;
    logic [31:0] mispredict_q;

    // Saturating statistics; survive flush, cleared only by reset.
    always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
        if (!cpu_resetn_i) begin
            resolved_q   <= '0;
            mispredict_q <= '0;
        end else begin
            if (accept && (resolved_q != '1)) begin
                resolved_q <= resolved_q + 32'd1;
            end
            if (accept && mispredict && (mispredict_q != '1)) begin
                mispredict_q <= mispredict_q + 32'd1;
            end
        end
    end

    assign resolved_count_o   = resolved_q;
    assign mispredict_count_o = mispredict_q;
`endif

endmodule

// File: tb/tb_biriq_branch_resolve.sv
// Scoreboard bench for biriq_branch_resolve: directed cases plus randomized
// traffic against a behavioural model using plain compares and arithmetic.
module tb_biriq_branch_resolve;

    logic clk;
    logic rst_n;
    logic flush;

    biriq_branch_resolve_if #(.XLEN(32), .RobIdW(6)) bus ();

`ifdef BIRIQ_BRANCH_STATS_EN
    logic [31:0] resolved_count;
    logic [31:0] mispredict_count;
`endif

    biriq_branch_resolve #(
        .C_XLEN            (32),
        .C_ROB_ID_W        (6),
        .C_HAS_C_EXTENSION (1'b0)
    ) dut (
        .cpu_clock_i        (clk),
        .cpu_resetn_i       (rst_n),
        .flush_i            (flush),
`ifdef BIRIQ_BRANCH_STATS_EN
        .resolved_count_o   (resolved_count),
        .mispredict_count_o (mispredict_count),
`endif
        .bus                (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        bit          flush;
        bit          wb_ready;
        bit          ack;
        logic [5:0]  rob;
        logic [2:0]  f3;
        logic [1:0]  kind;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        bit          pt;
        logic [31:0] ptgt;
    } stim_t;

    typedef struct {
        logic [5:0]  rob;
        logic [31:0] data;
        bit          exc;
        bit          redir;
        logic [31:0] rpc;
        logic [31:0] tgt;
    } exp_t;

    exp_t        exp_q[$];
    bit          model_redir = 1'b0;
    logic [31:0] model_rpc   = '0;
    int          n_checks    = 0;
    int          n_fail      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: branch outcome straight from the architectural rules on rs1/rs2.
    function automatic exp_t predict(input stim_t s);
        exp_t        e;
        bit          link;
        bit          taken;
        bit          mis;
        logic [31:0] npc;
        link = (s.kind == 2'd1) || (s.kind == 2'd2);
        if (link) begin
            taken = 1'b1;
        end else begin
            case (s.f3)
                3'b000:  taken = (s.rs1 == s.rs2);
                3'b001:  taken = (s.rs1 != s.rs2);
                3'b100:  taken = ($signed(s.rs1) < $signed(s.rs2));
                3'b101:  taken = ($signed(s.rs1) >= $signed(s.rs2));
                3'b110:  taken = (s.rs1 < s.rs2);
                3'b111:  taken = (s.rs1 >= s.rs2);
                default: taken = 1'b0;
            endcase
        end
        if (s.kind == 2'd2) e.tgt = (s.rs1 + s.imm) & 32'hFFFF_FFFE;
        else                e.tgt = s.pc + s.imm;
        npc     = taken ? e.tgt : s.pc + 32'd4;
        e.exc   = taken && e.tgt[1];
        mis     = (s.pt != taken) || (taken && (s.ptgt != e.tgt));
        e.redir = mis && !e.exc;
        e.rpc   = npc;
        e.data  = link ? s.pc + 32'd4 : 32'd0;
        e.rob   = s.rob;
        return e;
    endfunction

    function automatic stim_t idle(input bit rdy, input bit ack);
        stim_t s;
        s.valid = 0; s.flush = 0; s.wb_ready = rdy; s.ack = ack;
        s.rob = '0; s.f3 = '0; s.kind = '0; s.pc = '0; s.imm = '0;
        s.rs1 = '0; s.rs2 = '0; s.pt = 0; s.ptgt = '0;
        return s;
    endfunction

    function automatic stim_t mk_op(input logic [1:0] kind, input logic [2:0] f3,
                                    input logic [31:0] pc, input logic [31:0] imm,
                                    input logic [31:0] rs1, input logic [31:0] rs2,
                                    input bit pt, input logic [31:0] ptgt);
        stim_t s;
        s = idle(1'b1, 1'b0);
        s.valid = 1; s.rob = 6'($urandom_range(0, 63)); s.kind = kind; s.f3 = f3;
        s.pc = pc; s.imm = imm; s.rs1 = rs1; s.rs2 = rs2; s.pt = pt; s.ptgt = ptgt;
        return s;
    endfunction

    function automatic stim_t rand_op();
        stim_t s;
        exp_t  e;
        s = mk_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  $urandom & 32'hFFFF_FFFC, 32'd0, $urandom, $urandom, 1'b0, 32'd0);
        if ($urandom_range(0, 4) == 0) s.imm = $urandom;
        else s.imm = 32'(($urandom_range(0, 255) - 128) * 4);
        if ($urandom_range(0, 3) == 0) s.rs2 = s.rs1;
        if ($urandom_range(0, 3) == 0) s.rs2 = s.rs1 ^ 32'h8000_0000;
        s.pt = 1'($urandom);
        e = predict(s);
        s.ptgt = ($urandom_range(0, 1) == 0) ? e.tgt : $urandom;
        s.valid = ($urandom_range(0, 9) < 7);
        s.wb_ready = ($urandom_range(0, 9) < 7);
        s.ack = ($urandom_range(0, 9) < 3);
        s.flush = ($urandom_range(0, 99) < 3);
        return s;
    endfunction

    // One clock cycle: drive, check ready, then advance the model at the edge.
    task automatic step(input stim_t s);
        bit   model_ready;
        bit   acc;
        exp_t e;
        #1;
        bus.in_valid       = s.valid;
        bus.in_rob_id      = s.rob;
        bus.in_funct3      = s.f3;
        bus.in_kind        = s.kind;
        bus.in_pc          = s.pc;
        bus.in_imm         = s.imm;
        bus.in_rs1         = s.rs1;
        bus.in_mts         = ($signed(s.rs1) > $signed(s.rs2));
        bus.in_mtu         = (s.rs1 > s.rs2);
        bus.in_eq          = (s.rs1 == s.rs2);
        bus.in_pred_taken  = s.pt;
        bus.in_pred_target = s.ptgt;
        bus.wb_ready       = s.wb_ready;
        bus.redirect_ack   = s.ack;
        flush              = s.flush;
        #2;
        model_ready = !model_redir && ((exp_q.size() == 0) || s.wb_ready);
        check("in_ready", 64'(bus.in_ready), 64'(model_ready));
        acc = s.valid && model_ready && !s.flush;
        e   = predict(s);
        @(posedge clk);
        if (s.flush) begin
            exp_q.delete();
            model_redir = 1'b0;
        end else begin
            if (s.ack && model_redir) model_redir = 1'b0;
            if (acc) begin
                exp_q.push_back(e);
                if (e.redir) begin
                    model_redir = 1'b1;
                    model_rpc   = e.rpc;
                end
            end
        end
    endtask

    // Monitor: compare outputs against the model each cycle, retire on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("wb_valid", 64'(bus.wb_valid), 64'(exp_q.size() != 0));
                check("redirect", 64'(bus.redirect), 64'(model_redir));
                if (model_redir) check("redirect_pc", 64'(bus.redirect_pc), 64'(model_rpc));
                if (exp_q.size() != 0) begin
                    check("wb_rob_id", 64'(bus.wb_rob_id), 64'(exp_q[0].rob));
                    check("wb_data", 64'(bus.wb_data), 64'(exp_q[0].data));
                    check("wb_exc", 64'(bus.wb_exc), 64'(exp_q[0].exc));
                    if (bus.wb_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        stim_t s;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid = 0; bus.in_rob_id = '0; bus.in_funct3 = '0; bus.in_kind = '0;
        bus.in_pc = '0; bus.in_imm = '0; bus.in_rs1 = '0; bus.in_mts = 0; bus.in_mtu = 0;
        bus.in_eq = 0; bus.in_pred_taken = 0; bus.in_pred_target = '0;
        bus.wb_ready = 0; bus.redirect_ack = 0;
        #12;
        check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        check("rst_wb_data", 64'(bus.wb_data), 64'd0);
        check("rst_wb_rob_id", 64'(bus.wb_rob_id), 64'd0);
        check("rst_wb_exc", 64'(bus.wb_exc), 64'd0);
        check("rst_redirect", 64'(bus.redirect), 64'd0);
        check("rst_redirect_pc", 64'(bus.redirect_pc), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);

        // blt taken (rs1<rs2) predicted not-taken: redirect to 0x120, held until ack
        step(mk_op(2'd0, 3'b100, 32'h100, 32'h20, 32'd5, 32'd9, 1'b0, 32'd0));
        repeat (3) step(mk_op(2'd0, 3'b000, 32'h200, 32'h8, 32'd1, 32'd1, 1'b1, 32'h208));
        step(idle(1'b1, 1'b1));
        step(idle(1'b1, 1'b0));

        // bgeu taken (mtu) correctly predicted: no redirect, data 0
        step(mk_op(2'd0, 3'b111, 32'h40, 32'h40, 32'd9, 32'd5, 1'b1, 32'h80));
        step(idle(1'b1, 1'b0));

        // jalr to 0x1002: misaligned, exception and link, no redirect
        step(mk_op(2'd2, 3'b000, 32'h500, 32'h0, 32'h1003, 32'd0, 1'b1, 32'h1002));
        step(idle(1'b1, 1'b0));

        // jal wraps to 0x4; predicted 0x8 mispredicts
        step(mk_op(2'd1, 3'b000, 32'hFFFF_FFFC, 32'h8, 32'd0, 32'd0, 1'b1, 32'h8));
        step(idle(1'b1, 1'b0));
        step(idle(1'b1, 1'b1));
        step(idle(1'b1, 1'b0));

        // Writeback stall for 3 cycles, then back-to-back accept
        step(mk_op(2'd1, 3'b000, 32'h1000, 32'h10, 32'd0, 32'd0, 1'b1, 32'h1010));
        s = mk_op(2'd0, 3'b001, 32'h2000, 32'h40, 32'd3, 32'd4, 1'b1, 32'h2040);
        s.wb_ready = 1'b0;
        repeat (3) step(s);
        s.wb_ready = 1'b1;
        step(s);
        step(idle(1'b1, 1'b0));

        // Flush while redirecting with an op presented: op dropped, back to idle
        step(mk_op(2'd0, 3'b000, 32'h300, 32'h10, 32'd7, 32'd7, 1'b0, 32'd0));
        s = mk_op(2'd1, 3'b000, 32'h400, 32'h4, 32'd0, 32'd0, 1'b1, 32'h408);
        s.flush = 1'b1;
        s.ack   = 1'b1;
        step(s);
        step(idle(1'b1, 1'b0));
        step(idle(1'b1, 1'b0));

        // Randomized traffic
        for (int i = 0; i < 2000; i++) step(rand_op());

        // Drain
        repeat (4) step(idle(1'b1, 1'b1));
        check("drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/biriq_branch_resolve.md
Name: biriq_branch_resolve

Overview:
- Resolution stage behind the integer compare unit.
- Consumes one branch/jump micro-op plus the compare flags (mts/mtu/eq) for rs1 vs rs2 and decides the actual direction and target.
- Checks the outcome against the frontend prediction, writes back the link value, and raises a held redirect to the frontend on mispredict until it is acknowledged.
- Sits in the IXU between the compare unit and the ROB/frontend redirect path.

Parameters:
- C_XLEN, 32, datapath width.
- C_ROB_ID_W, 6, ROB tag width.
- C_HAS_C_EXTENSION, 0; 1 = 2-byte target alignment allowed, 0 = 4-byte required.

Ports:
- cpu_clock_i  in  1  core clock.
- cpu_resetn_i  in  1  asynchronous active-low reset.
- flush_i  in  1  pipeline flush from ROB; kills all state.
- in_valid_i  in  1  micro-op valid.
- in_ready_o  out  1  stage can accept.
- in_rob_id_i  in  C_ROB_ID_W  ROB tag.
- in_funct3_i  in  3  branch condition code.
- in_kind_i  in  2  operation kind: 00 branch, 01 jal, 10 jalr, 11 reserved (treated as branch).
- in_pc_i  in  C_XLEN  instruction PC.
- in_imm_i  in  C_XLEN  sign-extended offset.
- in_rs1_i  in  C_XLEN  rs1 value, for jalr.
- in_mts_i / in_mtu_i / in_eq_i  in  1 each  compare flags: rs1>rs2 signed, rs1>rs2 unsigned, rs1==rs2.
- in_pred_taken_i  in  1  predicted direction.
- in_pred_target_i  in  C_XLEN  predicted target.
- wb_valid_o  out  1  result valid.
- wb_ready_i  in  1  writeback accepts.
- wb_rob_id_o  out  C_ROB_ID_W  tag.
- wb_data_o  out  C_XLEN  link value pc+4 (jal/jalr), 0 for branch.
- wb_exc_o  out  1  misaligned target on a taken path.
- redirect_o  out  1  redirect request.
- redirect_pc_o  out  C_XLEN  correct next PC.
- redirect_ack_i  in  1  frontend accepted redirect.

Behaviour:
- Reset (async, active-low): all outputs 0; FSM in IDLE.
- Direction:
  - beq=eq, bne=!eq.
  - blt = !(mts|eq), bge = mts|eq.
  - bltu = !(mtu|eq), bgeu = mtu|eq.
  - funct3 010/011 never taken.
  - jal/jalr are always taken.
- Target arithmetic: modulo 2^C_XLEN, wrap-around permitted.
  - branch/jal: pc+imm.
  - jalr: (rs1+imm) with bit0 cleared.
- Correct next PC: taken ? target : pc+4.
- Mispredict: pred_taken != taken, or (taken && pred_target != target).
- Exception: taken and target[1] set when C_HAS_C_EXTENSION=0. On exception, no redirect is raised; the ROB handles the trap.
- in_ready_o = (state==IDLE) && (!wb_valid_o || wb_ready_i).
- Accept on in_valid_i && in_ready_o. The wb_* registers load the next cycle, so latency is 1 cycle.
- wb_* outputs hold stable while wb_valid_o && !wb_ready_i.
- FSM:
  - IDLE → REDIRECT when an accepted op mispredicts without exception. redirect_o and redirect_pc_o are registered in the same cycle as wb.
  - REDIRECT: redirect_o held high, redirect_pc_o stable, in_ready_o=0.
  - REDIRECT → IDLE on redirect_ack_i.
  - An ack in the same cycle as redirect assertion is not possible, since the ack is only sampled while redirect_o=1.
- flush_i has priority over everything:
  - next cycle wb_valid_o=0, redirect_o=0, state=IDLE;
  - an op presented in the flush cycle is dropped;
  - flush together with redirect_ack_i: result is IDLE.
- Simultaneous wb_ready_i and a new accept: the output register is overwritten with no bubble.

Optional Feature:
- Macro BIRIQ_BRANCH_STATS_EN.
- Defined:
  - adds 32-bit saturating counters, resolved_count_o and mispredict_count_o;
  - increment on accept and on mispredict respectively;
  - cleared only by reset, not by flush.
- Undefined: ports and counters absent; no other change.

Decomposition:
- Package biriq_branch_pkg:
  - kind enum (BR, JAL, JALR);
  - funct3 constants (BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111);
  - FSM state enum (IDLE, REDIRECT).
- Sub-module biriq_branch_cond: combinational funct3+flags → taken. Reused by frontend checks.

Test Plan:
- blt, mts=0, eq=0, pred_taken=0, pc=0x100, imm=0x20: 1 cycle later wb_valid_o=1, redirect_o=1, redirect_pc_o=0x120; held until ack, in_ready_o=0 meanwhile.
- bgeu, mtu=1, pred_taken=1, pred_target=0x80, pc=0x40, imm=0x40: no redirect, wb_data_o=0.
- jalr, rs1=0x1003, imm=0, pred_target=0x1002, C_HAS_C_EXTENSION=0: wb_exc_o=1, wb_data_o=pc+4, no redirect.
- jal, pc=0xFFFFFFFC, imm=8: target wraps to 0x4; mispredict if pred_target≠0x4.
- wb_ready_i=0 for 3 cycles with wb valid: outputs stable, in_ready_o=0; on ready, back-to-back accept with no bubble.
- flush_i asserted in REDIRECT with an op presented: next cycle redirect_o=0, wb_valid_o=0, IDLE; the op is dropped.
